// File: rtl/hps_coord_mailbox.sv
// Mailbox between HPS PIO export words and fabric: waits for the inputs to go quiet,
// commits a coherent multi-channel snapshot into a FWFT FIFO and shows one channel on hex digits.
module hps_coord_mailbox #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned HEX_DIGITS    = 4,
    localparam int unsigned SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned FILL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] pio_data,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FILL_W-1:0]        fill_level,
    output logic [15:0]              ovf_count,
    input  logic [SEL_W-1:0]         hex_sel,
    output logic [HEX_DIGITS*7-1:0]  hex_seg
);

    localparam int unsigned BUS_W  = NUM_CH * DATA_W;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned NIB_W  = HEX_DIGITS * 4;
    localparam int unsigned SNAP_W = NUM_CH * NIB_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BUS_W-1:0]    pio_q, pio_d;
    logic [SNAP_W-1:0]   last_snap_q, last_snap_d;
    logic [BUS_W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [15:0]         ovf_q, ovf_d;
    logic [HEX_DIGITS*7-1:0] hex_q, hex_d;

    logic change;
    logic settled;
    logic commit;
    logic full;
    logic pop;
    logic push;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign pio_d   = pio_data;
    assign change  = (pio_data != pio_q);
    assign settled = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (change) state_d = S_SETTLE;
            S_SETTLE: if (!change && settled) state_d = S_COMMIT;
            S_COMMIT: state_d = change ? S_SETTLE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: quiet-cycle counter and the one-cycle commit strobe
    always_comb begin
        cnt_d  = '0;
        commit = 1'b0;
        case (state_q)
            S_SETTLE: if (!change && !settled) cnt_d = cnt_q + CNT_W'(1);
            S_COMMIT: commit = 1'b1;
            default:  ;
        endcase
    end

    // A full FIFO still has room when the head leaves in the same cycle
    assign full = (fill_q == FILL_W'(FIFO_DEPTH));
    assign pop  = (fill_q != '0) && out_ready;
    assign push = commit && (!full || pop);

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d      = fill_q;
        ovf_d       = ovf_q;
        last_snap_d = last_snap_q;
        if (push && !pop) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - FILL_W'(1);
        end
        if (commit && !push && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        // Only the nibbles that can reach the display are kept per channel
        if (commit) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                last_snap_d[k*NIB_W +: NIB_W] = pio_q[k*DATA_W +: NIB_W];
            end
        end
    end

    always_comb begin
        hex_d = '1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(hex_sel) == k) begin
                for (int unsigned i = 0; i < HEX_DIGITS; i++) begin
                    hex_d[i*7 +: 7] = seg7(last_snap_q[k*NIB_W + i*4 +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            pio_q       <= '0;
            last_snap_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            ovf_q       <= '0;
            hex_q       <= '1;
        end else begin
            cnt_q       <= cnt_d;
            pio_q       <= pio_d;
            last_snap_q <= last_snap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            hex_q       <= hex_d;
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pio_q;
        end
    end

    assign out_valid  = (fill_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_level = fill_q;
    assign ovf_count  = ovf_q;
    assign hex_seg    = hex_q;

endmodule
